// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if: OBI request/response bundle between a core port and its responder
interface obi_mem_responder_if #(parameter int DATA_W = 32) ();
   logic              req_i;
   logic [DATA_W-1:0] addr_i;
   logic              we_i;
   logic [DATA_W/8-1:0] be_i;
   logic [DATA_W-1:0] wdata_i;
   logic              gnt_o;
   logic              rvalid_o;
   logic [DATA_W-1:0] rdata_o;
   modport master (output req_i, addr_i, we_i, be_i, wdata_i, input gnt_o, rvalid_o, rdata_o);
   modport slave (input req_i, addr_i, we_i, be_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: in-order, bounded-latency OBI responder driven by free-choice inputs.
// Define OBI_RESP_ASSERT_EN to embed protocol checks, covers and the sticky err_o flag.
module obi_mem_responder #(
   parameter int DEPTH     = 2,
   parameter int MAX_STALL = 3,
   parameter int MAX_LAT   = 3,
   parameter int DATA_W    = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   obi_mem_responder_if.slave       bus,
   input  logic                     stall_i,
   input  logic                     delay_i,
   input  logic [DATA_W-1:0]        rand_rdata_i,
   output logic [$clog2(DEPTH):0]   outstanding_o,
   output logic                     err_o
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int SW = MAX_STALL > 0 ? $clog2(MAX_STALL + 1) : 1;
   localparam int LW = MAX_LAT > 0 ? $clog2(MAX_LAT + 1) : 1;

   logic [PW-1:0] head_q, head_d, tail_q, tail_d, count;
   logic [SW-1:0] stall_q, stall_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          full, empty, push, pop;
   logic          we_mem   [2**AW];
   logic [DATA_W-1:0] addr_mem [2**AW];

   always_comb begin
      count   = tail_q - head_q;
      full    = count == PW'(DEPTH);
      empty   = tail_q == head_q;
      push    = !reset && bus.req_i && !full && (!stall_i || stall_q == SW'(MAX_STALL));
      pop     = !reset && !empty && (!delay_i || lat_q == LW'(MAX_LAT));
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      stall_d = (!bus.req_i || push) ? '0 : stall_q == SW'(MAX_STALL) ? stall_q : stall_q + SW'(1);
      lat_d   = (empty || pop) ? '0 : lat_q == LW'(MAX_LAT) ? lat_q : lat_q + LW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         stall_q <= '0;
         lat_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         stall_q <= stall_d;
         lat_q   <= lat_d;
      end
   end

   // Payload storage needs no reset: validity comes solely from the pointers.
   always_ff @(posedge clock) begin
      if (push) begin
         we_mem[tail_q[AW-1:0]]   <= bus.we_i;
         addr_mem[tail_q[AW-1:0]] <= bus.addr_i;
      end
   end

   assign bus.gnt_o     = push;
   assign bus.rvalid_o  = pop;
   assign bus.rdata_o   = (pop && !we_mem[head_q[AW-1:0]]) ? rand_rdata_i : '0;
   assign outstanding_o = count;

   logic unused_bits;
   assign unused_bits = ^{bus.be_i, bus.wdata_i, addr_mem[head_q[AW-1:0]]};

`ifdef OBI_RESP_ASSERT_EN
   logic                pend_q, pwe_q, err_q, viol;
   logic [DATA_W-1:0]   paddr_q, pwdata_q;
   logic [DATA_W/8-1:0] pbe_q;

   always_comb begin
      viol = (pend_q && (!bus.req_i || bus.addr_i != paddr_q || bus.we_i != pwe_q ||
                         bus.be_i != pbe_q || bus.wdata_i != pwdata_q)) ||
             count > PW'(DEPTH) || (pop && empty);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_q   <= 1'b0;
         pwe_q    <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pbe_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         pend_q   <= bus.req_i && !push;
         pwe_q    <= bus.we_i;
         paddr_q  <= bus.addr_i;
         pwdata_q <= bus.wdata_i;
         pbe_q    <= bus.be_i;
         err_q    <= err_q | viol;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) assert (!viol);
   end

   cover property (@(posedge clock) disable iff (reset) full);
   cover property (@(posedge clock) disable iff (reset) stall_q == SW'(MAX_STALL));
   cover property (@(posedge clock) disable iff (reset) lat_q == LW'(MAX_LAT));

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: directed checks of grant, response ordering, fairness bounds and reset flush
module tb_obi_mem_responder;
   logic        clock = 1'b0;
   logic        reset;
   logic        stall_i, delay_i;
   logic [31:0] rand_rdata_i;
   logic [1:0]  outstanding_o;
   logic        err_o;
   int          tests = 0;
   int          fails = 0;

   obi_mem_responder_if #(.DATA_W(32)) bus ();

   obi_mem_responder #(.DEPTH(2), .MAX_STALL(3), .MAX_LAT(3), .DATA_W(32)) dut (
      .clock(clock), .reset(reset), .bus(bus), .stall_i(stall_i), .delay_i(delay_i),
      .rand_rdata_i(rand_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clock = ~clock;

   task automatic idle();
      bus.req_i = 0; bus.addr_i = 0; bus.we_i = 0; bus.be_i = 4'hF; bus.wdata_i = 0;
      stall_i = 0; delay_i = 0; rand_rdata_i = 0;
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      bus.req_i = 1;
      #2;
      tests++; if (bus.gnt_o !== 1'b0) begin fails++; $display("FAIL reset_gnt got %b want 0", bus.gnt_o); end
      tests++; if (bus.rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid_o); end
      tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", bus.rdata_o); end
      tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL reset_outstanding got %0d want 0", outstanding_o); end
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_o); end
      cyc(); cyc();
      idle();
      reset = 0;
      cyc();
   endtask

   task automatic test_basic_read();
      bus.req_i = 1; bus.addr_i = 32'h1A000080; bus.we_i = 0; rand_rdata_i = 32'h00000013;
      #1;
      tests++; if (bus.gnt_o !== 1'b1) begin fails++; $display("FAIL basic_gnt got %b want 1", bus.gnt_o); end
      tests++; if (bus.rvalid_o !== 1'b0) begin fails++; $display("FAIL basic_rvalid0 got %b want 0", bus.rvalid_o); end
      cyc();
      bus.req_i = 0;
      #1;
      tests++; if (bus.rvalid_o !== 1'b1) begin fails++; $display("FAIL basic_rvalid got %b want 1", bus.rvalid_o); end
      tests++; if (bus.rdata_o !== 32'h00000013) begin fails++; $display("FAIL basic_rdata got %h want 00000013", bus.rdata_o); end
      tests++; if (outstanding_o !== 2'd1) begin fails++; $display("FAIL basic_outstanding1 got %0d want 1", outstanding_o); end
      cyc();
      #1;
      tests++; if (bus.rvalid_o !== 1'b0) begin fails++; $display("FAIL basic_rvalid_after got %b want 0", bus.rvalid_o); end
      tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL basic_rdata_idle got %h want 0", bus.rdata_o); end
      tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL basic_outstanding0 got %0d want 0", outstanding_o); end
      cyc();
   endtask

   task automatic test_stall();
      bus.req_i = 1; bus.addr_i = 32'h00000100; stall_i = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (bus.gnt_o !== (i == 3)) begin fails++; $display("FAIL stall_gnt[%0d] got %b want %b", i, bus.gnt_o, i == 3); end
         cyc();
      end
      idle();
      #1;
      tests++; if (bus.rvalid_o !== 1'b1) begin fails++; $display("FAIL stall_rvalid got %b want 1", bus.rvalid_o); end
      cyc();
      #1;
      tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL stall_drain got %0d want 0", outstanding_o); end
      cyc();
   endtask

   task automatic test_full();
      logic [5:0] exp_gnt, exp_rv;
      exp_gnt = 6'b100011;
      exp_rv  = 6'b010000;
      bus.req_i = 1; bus.addr_i = 32'h00000200; delay_i = 1; rand_rdata_i = 32'h00000055;
      for (int i = 0; i < 6; i++) begin
         #1;
         tests++; if (bus.gnt_o !== exp_gnt[i]) begin fails++; $display("FAIL full_gnt[%0d] got %b want %b", i, bus.gnt_o, exp_gnt[i]); end
         tests++; if (bus.rvalid_o !== exp_rv[i]) begin fails++; $display("FAIL full_rvalid[%0d] got %b want %b", i, bus.rvalid_o, exp_rv[i]); end
         if (i == 4) begin
            tests++; if (bus.rdata_o !== 32'h00000055) begin fails++; $display("FAIL full_rdata got %h want 00000055", bus.rdata_o); end
         end
         if (i == 2) begin
            tests++; if (outstanding_o !== 2'd2) begin fails++; $display("FAIL full_count got %0d want 2", outstanding_o); end
         end
         cyc();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (bus.rvalid_o !== (i < 2)) begin fails++; $display("FAIL full_drain[%0d] got %b want %b", i, bus.rvalid_o, i < 2); end
         cyc();
      end
      #1;
      tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL full_empty got %0d want 0", outstanding_o); end
      cyc();
   endtask

   task automatic test_write_read();
      bus.req_i = 1; bus.we_i = 1; bus.addr_i = 32'h00000300; bus.wdata_i = 32'hDEADBEEF;
      rand_rdata_i = 32'hCAFE0001;
      #1;
      tests++; if (bus.gnt_o !== 1'b1) begin fails++; $display("FAIL wr_gnt got %b want 1", bus.gnt_o); end
      cyc();
      bus.we_i = 0; bus.addr_i = 32'h00000304; bus.wdata_i = 0;
      #1;
      tests++; if (bus.gnt_o !== 1'b1) begin fails++; $display("FAIL rd_gnt got %b want 1", bus.gnt_o); end
      tests++; if (bus.rvalid_o !== 1'b1) begin fails++; $display("FAIL wr_rvalid got %b want 1", bus.rvalid_o); end
      tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL wr_rdata got %h want 0", bus.rdata_o); end
      cyc();
      bus.req_i = 0; rand_rdata_i = 32'h12345678;
      #1;
      tests++; if (outstanding_o !== 2'd1) begin fails++; $display("FAIL pushpop_count got %0d want 1", outstanding_o); end
      tests++; if (bus.rvalid_o !== 1'b1) begin fails++; $display("FAIL rd_rvalid got %b want 1", bus.rvalid_o); end
      tests++; if (bus.rdata_o !== 32'h12345678) begin fails++; $display("FAIL rd_rdata got %h want 12345678", bus.rdata_o); end
      cyc();
      #1;
      tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL wr_rd_empty got %0d want 0", outstanding_o); end
      idle();
      cyc();
   endtask

   task automatic test_reset_flush();
      bus.req_i = 1; bus.addr_i = 32'h00000400; delay_i = 1;
      cyc(); cyc();
      bus.req_i = 0;
      #1;
      tests++; if (outstanding_o !== 2'd2) begin fails++; $display("FAIL flush_pre got %0d want 2", outstanding_o); end
      reset = 1;
      #1;
      tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL flush_count got %0d want 0", outstanding_o); end
      tests++; if (bus.rvalid_o !== 1'b0) begin fails++; $display("FAIL flush_rvalid got %b want 0", bus.rvalid_o); end
      cyc();
      reset = 0; delay_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (bus.rvalid_o !== 1'b0) begin fails++; $display("FAIL flush_stale[%0d] got %b want 0", i, bus.rvalid_o); end
         tests++; if (outstanding_o !== 2'd0) begin fails++; $display("FAIL flush_idle[%0d] got %0d want 0", i, outstanding_o); end
         cyc();
      end
   endtask

   task automatic test_err();
`ifdef OBI_RESP_ASSERT_EN
      bus.req_i = 1; bus.addr_i = 32'h00000500; stall_i = 1;
      cyc();
      bus.addr_i = 32'h00000504;
      cyc();
      #1;
      tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err_o); end
      idle();
      cyc(); cyc();
      #1;
      tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err_o); end
      reset = 1;
      #1;
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err_o); end
      cyc();
      reset = 0;
      cyc();
`else
      #1;
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_tied got %b want 0", err_o); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_stall();
      test_full();
      test_write_read();
      test_reset_flush();
      test_err();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
